// File: rtl/wgt_buf_sched_if.sv
// -----------------------------------------------------------------------------
// wgt_buf_sched_if
//   Bundles the layer-controller, array flow-control and weight-buffer signals
//   of the weight-buffer tile scheduler.
//
//   Controller side : start, abort, cfg_mode, cfg_len, cfg_cols, cfg_reps
//   Array side      : array_ready, burst_ack
//   Weight buffer   : wbuf_on, wbuf_mode, wbuf_base_addr, wbuf_num_cols
//   Status          : busy, done, cfg_err
//
//   modport master : the environment driving the scheduler (controller + array)
//   modport slave  : the scheduler itself
// -----------------------------------------------------------------------------
interface wgt_buf_sched_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int ARRAY_M    = 8,
    parameter int DIM_WIDTH  = 8
);
    localparam int CW = $clog2(ARRAY_M) + 1;

    logic                  start;
    logic                  abort;
    logic                  cfg_mode;
    logic [DIM_WIDTH-1:0]  cfg_len;
    logic [DIM_WIDTH-1:0]  cfg_cols;
    logic [DIM_WIDTH-1:0]  cfg_reps;
    logic                  array_ready;
    logic                  burst_ack;

    logic                  wbuf_on;
    logic                  wbuf_mode;
    logic [ADDR_WIDTH-1:0] wbuf_base_addr;
    logic [CW-1:0]         wbuf_num_cols;
    logic                  busy;
    logic                  done;
    logic                  cfg_err;

    modport master (
        output start, abort, cfg_mode, cfg_len, cfg_cols, cfg_reps,
        output array_ready, burst_ack,
        input  wbuf_on, wbuf_mode, wbuf_base_addr, wbuf_num_cols,
        input  busy, done, cfg_err
    );

    modport slave (
        input  start, abort, cfg_mode, cfg_len, cfg_cols, cfg_reps,
        input  array_ready, burst_ack,
        output wbuf_on, wbuf_mode, wbuf_base_addr, wbuf_num_cols,
        output busy, done, cfg_err
    );
endinterface

// File: rtl/wgt_buf_sched.sv
// -----------------------------------------------------------------------------
// wgt_buf_sched
//   Tile scheduler for the weight buffer. Walks a weight matrix one column tile
//   (at most ARRAY_M columns) at a time and issues one read burst of cfg_len
//   cycles per tile (WS) or cfg_reps bursts per tile (OS), waiting for the
//   array to be ready before each burst and to acknowledge it afterwards.
//
//   Ports:
//     clk    : clock
//     reset  : asynchronous active-low reset
//     bus    : wgt_buf_sched_if.slave
//              start/abort/cfg_*   layer control and configuration (in)
//              array_ready/burst_ack  per-burst flow control (in)
//              wbuf_on/mode/base_addr/num_cols  weight-buffer controls (out)
//              busy/done/cfg_err   status (out)
//
//   All outputs are registered. Output registers are loaded from the next
//   state, so wbuf_on is high exactly in the BURST cycles and done/cfg_err
//   are high exactly in the DONE cycle.
// -----------------------------------------------------------------------------
module wgt_buf_sched #(
    parameter int ADDR_WIDTH = 8,
    parameter int ARRAY_M    = 8,
    parameter int DIM_WIDTH  = 8
) (
    input  logic              clk,
    input  logic              reset,
    wgt_buf_sched_if.slave    bus
);
    localparam int CW = $clog2(ARRAY_M) + 1;
    // Tile count and tile index need one extra bit of headroom.
    localparam int TW = DIM_WIDTH + 1;
    // T*cfg_len must be computed without truncation and compared against
    // 2^ADDR_WIDTH, so the product width covers both.
    localparam int PW = (2 * DIM_WIDTH + 1 > ADDR_WIDTH + 1) ?
                        2 * DIM_WIDTH + 1 : ADDR_WIDTH + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_WAIT_RDY,
        S_BURST,
        S_WAIT_ACK,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic                  mode_q, mode_d;
    logic [DIM_WIDTH-1:0]  len_q, len_d;
    logic [DIM_WIDTH-1:0]  cols_q, cols_d;
    logic [DIM_WIDTH-1:0]  reps_q, reps_d;
    logic                  err_q, err_d;
    logic [TW-1:0]         t_q, t_d;
    logic [DIM_WIDTH-1:0]  r_q, r_d;
    logic [DIM_WIDTH-1:0]  cyc_q, cyc_d;
    logic [ADDR_WIDTH-1:0] acc_q, acc_d;      // t*cfg_len, built by accumulation
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [CW-1:0]         ncols_q, ncols_d;
    logic                  on_q, busy_q, done_q, cerr_q;

    // Derived from the latched configuration only.
    logic [TW-1:0] tiles;
    logic [TW-1:0] last_t;
    logic [PW-1:0] span;
    logic [TW-1:0] rem;
    logic [CW-1:0] last_cols;
    logic          illegal;
    logic          is_last_tile;
    logic          last_rep;
    logic          burst_end;

    assign tiles     = (TW'(cols_q) + TW'(ARRAY_M - 1)) / TW'(ARRAY_M);
    assign last_t    = tiles - TW'(1);
    assign span      = PW'(tiles) * PW'(len_q);
    assign illegal   = (len_q == '0) || (cols_q == '0) || (reps_q == '0) ||
                       (span > (PW'(1) << ADDR_WIDTH));
    // Edge-tile width: cols - (T-1)*ARRAY_M, i.e. the remainder, or a full
    // tile when the column count divides evenly.
    assign rem       = TW'(cols_q) % TW'(ARRAY_M);
    assign last_cols = (rem == '0) ? CW'(ARRAY_M) : CW'(rem);

    assign is_last_tile = (t_q == last_t);
    assign last_rep     = (r_q == reps_q - DIM_WIDTH'(1));
    assign burst_end    = (cyc_q == len_q - DIM_WIDTH'(1));

    // NOTE: every variable driven here gets its hold value first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        len_d   = len_q;
        cols_d  = cols_q;
        reps_d  = reps_q;
        err_d   = err_q;
        t_d     = t_q;
        r_d     = r_q;
        cyc_d   = cyc_q;
        acc_d   = acc_q;
        base_d  = base_q;
        ncols_d = ncols_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    mode_d  = bus.cfg_mode;
                    len_d   = bus.cfg_len;
                    cols_d  = bus.cfg_cols;
                    reps_d  = bus.cfg_reps;
                    state_d = S_CHECK;
                end
            end

            S_CHECK: begin
                err_d   = illegal;
                t_d     = '0;
                r_d     = '0;
                acc_d   = '0;
                state_d = illegal ? S_DONE : S_WAIT_RDY;
            end

            S_WAIT_RDY: begin
                if (bus.array_ready) begin
                    // Tile controls are captured here and held until the next
                    // burst starts, so they are valid on the first wbuf_on cycle.
                    cyc_d   = '0;
                    base_d  = acc_q;
                    ncols_d = is_last_tile ? last_cols : CW'(ARRAY_M);
                    state_d = S_BURST;
                end
            end

            S_BURST: begin
                if (burst_end) begin
                    state_d = S_WAIT_ACK;
                end else begin
                    cyc_d = cyc_q + DIM_WIDTH'(1);
                end
            end

            S_WAIT_ACK: begin
                if (bus.burst_ack) begin
                    // WS gives each tile a single burst, so only the tile
                    // index decides the end of the layer.
                    if (is_last_tile && (!mode_q || last_rep)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WAIT_RDY;
                        if (mode_q && !last_rep) begin
                            r_d = r_q + DIM_WIDTH'(1);
                        end else begin
                            r_d   = '0;
                            t_d   = t_q + TW'(1);
                            acc_d = acc_q + ADDR_WIDTH'(len_q);
                        end
                    end
                end
            end

            S_DONE: state_d = S_IDLE;

            default: state_d = S_IDLE;
        endcase

        // Abort overrides every transition, including the one into DONE.
        if (bus.abort) begin
            state_d = S_IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            mode_q  <= 1'b0;
            len_q   <= '0;
            cols_q  <= '0;
            reps_q  <= '0;
            err_q   <= 1'b0;
            t_q     <= '0;
            r_q     <= '0;
            cyc_q   <= '0;
            acc_q   <= '0;
            base_q  <= '0;
            ncols_q <= '0;
            on_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            len_q   <= len_d;
            cols_q  <= cols_d;
            reps_q  <= reps_d;
            err_q   <= err_d;
            t_q     <= t_d;
            r_q     <= r_d;
            cyc_q   <= cyc_d;
            acc_q   <= acc_d;
            base_q  <= base_d;
            ncols_q <= ncols_d;
            on_q    <= (state_d == S_BURST);
            busy_q  <= (state_d != S_IDLE);
            done_q  <= (state_d == S_DONE);
            cerr_q  <= (state_d == S_DONE) && err_d;
        end
    end

    assign bus.wbuf_on        = on_q;
    assign bus.wbuf_mode      = mode_q;
    assign bus.wbuf_base_addr = base_q;
    assign bus.wbuf_num_cols  = ncols_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.cfg_err        = cerr_q;

endmodule

// File: tb/tb_wgt_buf_sched.sv
// -----------------------------------------------------------------------------
// tb_wgt_buf_sched
//   Directed bench for wgt_buf_sched. Each started layer pushes its expected
//   bursts (base address, column count, length) into a queue; a monitor pops
//   one entry at every rising edge of wbuf_on and compares it against the
//   weight-buffer controls for the whole burst.
// -----------------------------------------------------------------------------
module tb_wgt_buf_sched;
    localparam int AW = 8;
    localparam int M  = 8;
    localparam int DW = 8;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    wgt_buf_sched_if #(.ADDR_WIDTH(AW), .ARRAY_M(M), .DIM_WIDTH(DW)) bus ();

    wgt_buf_sched #(.ADDR_WIDTH(AW), .ARRAY_M(M), .DIM_WIDTH(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int base;
        int ncols;
        int len;
    } burst_t;

    burst_t sb[$];
    int     n_assert    = 0;
    int     n_fail      = 0;
    int     bursts_seen = 0;
    int     done_cnt    = 0;
    bit     skip_len    = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Burst monitor / scoreboard consumer.
    initial begin
        logic   prev_on;
        int     run;
        burst_t cur;
        prev_on = 1'b0;
        run     = 0;
        cur     = '{0, 0, 0};
        forever begin
            @(negedge clk);
            if (bus.done === 1'b1) done_cnt++;
            if (bus.wbuf_on === 1'b1) begin
                if (!prev_on) begin
                    bursts_seen++;
                    run = 1;
                    if (sb.size() == 0) begin
                        check("unexpected_burst", 32'(sb.size()), 32'd1);
                    end else begin
                        cur = sb.pop_front();
                    end
                end else begin
                    run++;
                end
                check("base_addr", 32'(bus.wbuf_base_addr), 32'(cur.base));
                check("num_cols", 32'(bus.wbuf_num_cols), 32'(cur.ncols));
            end else if (prev_on && !skip_len) begin
                check("burst_len", 32'(run), 32'(cur.len));
            end
            prev_on = bus.wbuf_on;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic push_bursts(input bit os, input int len, input int cols, input int reps,
                               output int count);
        int tiles;
        tiles = (cols + M - 1) / M;
        count = 0;
        for (int t = 0; t < tiles; t++) begin
            for (int r = 0; r < (os ? reps : 1); r++) begin
                burst_t b;
                b.base  = t * len;
                b.ncols = (t == tiles - 1) ? cols - (tiles - 1) * M : M;
                b.len   = len;
                sb.push_back(b);
                count++;
            end
        end
    endtask

    // Returns at the negedge in cycle 1 (start sampled at edge 0).
    task automatic do_start(input bit os, input int len, input int cols, input int reps);
        @(negedge clk);
        bus.cfg_mode = os;
        bus.cfg_len  = DW'(len);
        bus.cfg_cols = DW'(cols);
        bus.cfg_reps = DW'(reps);
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start    = 1'b0;
        // Post-latch changes must have no effect.
        bus.cfg_mode = ~os;
        bus.cfg_len  = DW'($urandom);
        bus.cfg_cols = DW'($urandom);
        bus.cfg_reps = DW'($urandom);
    endtask

    task automatic wait_on(input int budget);
        int k;
        k = 0;
        while (bus.wbuf_on !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("wbuf_on_seen", 32'(bus.wbuf_on), 32'd1);
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (bus.done !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("done_seen", 32'(bus.done), 32'd1);
        check("cfg_err_at_done", 32'(bus.cfg_err), 32'd0);
        check("wbuf_on_at_done", 32'(bus.wbuf_on), 32'd0);
        @(negedge clk);
        check("busy_after_done", 32'(bus.busy), 32'd0);
        check("done_single_pulse", 32'(bus.done), 32'd0);
    endtask

    task automatic run_case(input bit os, input int len, input int cols, input int reps);
        int n_exp, b0, d0;
        b0 = bursts_seen;
        d0 = done_cnt;
        push_bursts(os, len, cols, reps, n_exp);
        do_start(os, len, cols, reps);
        check("wbuf_mode", 32'(bus.wbuf_mode), 32'(os));
        wait_done(2000);
        check("sb_empty", 32'(sb.size()), 32'd0);
        check("burst_count", 32'(bursts_seen - b0), 32'(n_exp));
        check("done_count", 32'(done_cnt - d0), 32'd1);
    endtask

    task automatic run_illegal(input int len, input int cols, input int reps);
        int b0;
        b0 = bursts_seen;
        do_start(1'b1, len, cols, reps);
        check("ill_c1_done", 32'(bus.done), 32'd0);
        check("ill_c1_busy", 32'(bus.busy), 32'd1);
        @(negedge clk);
        check("ill_c2_done", 32'(bus.done), 32'd1);
        check("ill_c2_cfg_err", 32'(bus.cfg_err), 32'd1);
        check("ill_c2_wbuf_on", 32'(bus.wbuf_on), 32'd0);
        @(negedge clk);
        check("ill_c3_busy", 32'(bus.busy), 32'd0);
        check("ill_c3_done", 32'(bus.done), 32'd0);
        check("ill_c3_cfg_err", 32'(bus.cfg_err), 32'd0);
        check("ill_no_burst", 32'(bursts_seen - b0), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_wbuf_on"}, 32'(bus.wbuf_on), 32'd0);
        check({tag, "_wbuf_mode"}, 32'(bus.wbuf_mode), 32'd0);
        check({tag, "_base_addr"}, 32'(bus.wbuf_base_addr), 32'd0);
        check({tag, "_num_cols"}, 32'(bus.wbuf_num_cols), 32'd0);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_done"}, 32'(bus.done), 32'd0);
        check({tag, "_cfg_err"}, 32'(bus.cfg_err), 32'd0);
    endtask

    initial begin
        int n_exp, b0, d0, cnt;

        bus.start       = 1'b0;
        bus.abort       = 1'b0;
        bus.cfg_mode    = 1'b0;
        bus.cfg_len     = '0;
        bus.cfg_cols    = '0;
        bus.cfg_reps    = '0;
        bus.array_ready = 1'b1;
        bus.burst_ack   = 1'b1;

        // Reset state.
        repeat (3) @(negedge clk);
        check_reset_values("rst");
        reset = 1'b1;
        @(negedge clk);
        check("idle_busy", 32'(bus.busy), 32'd0);

        // OS, 20 columns, len 4: bursts at 0/4/8 with 8/8/4 columns,
        // plus start-up timing and a start pulse while busy.
        b0 = bursts_seen;
        d0 = done_cnt;
        push_bursts(1'b1, 4, 20, 1, n_exp);
        do_start(1'b1, 4, 20, 1);
        check("c1_busy", 32'(bus.busy), 32'd1);
        check("c1_wbuf_on", 32'(bus.wbuf_on), 32'd0);
        check("c1_wbuf_mode", 32'(bus.wbuf_mode), 32'd1);
        @(negedge clk);
        check("c2_wbuf_on", 32'(bus.wbuf_on), 32'd0);
        @(negedge clk);
        check("c3_wbuf_on", 32'(bus.wbuf_on), 32'd1);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(500);
        check("os20_sb_empty", 32'(sb.size()), 32'd0);
        check("os20_bursts", 32'(bursts_seen - b0), 32'(n_exp));
        check("os20_done_count", 32'(done_cnt - d0), 32'd1);
        @(negedge clk);
        check("start_while_busy_ignored", 32'(bus.busy), 32'd0);

        // Reps: OS gives two bursts on the single tile, WS gives one.
        run_case(1'b1, 3, 8, 2);
        run_case(1'b0, 3, 8, 2);

        // WS 17 columns with array_ready low for 10 cycles before burst 2.
        b0 = bursts_seen;
        push_bursts(1'b0, 5, 17, 3, n_exp);
        do_start(1'b0, 5, 17, 3);
        wait_on(50);
        bus.array_ready = 1'b0;
        cnt = 0;
        while (bus.wbuf_on === 1'b1 && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.wbuf_on !== 1'b0) cnt++;
        end
        check("on_while_not_ready", 32'(cnt), 32'd0);
        check("busy_while_not_ready", 32'(bus.busy), 32'd1);
        bus.array_ready = 1'b1;
        wait_done(500);
        check("ws17_sb_empty", 32'(sb.size()), 32'd0);
        check("ws17_bursts", 32'(bursts_seen - b0), 32'(n_exp));

        // Illegal configurations, then the exact 2^ADDR_WIDTH boundary.
        run_illegal(0, 20, 1);
        run_illegal(100, 24, 1);
        run_illegal(4, 0, 1);
        run_illegal(4, 20, 0);
        run_case(1'b0, 64, 32, 1);

        // Abort in the second cycle of a burst.
        push_bursts(1'b0, 5, 17, 1, n_exp);
        d0 = done_cnt;
        do_start(1'b0, 5, 17, 1);
        wait_on(50);
        @(negedge clk);
        check("abort_pre_on", 32'(bus.wbuf_on), 32'd1);
        skip_len  = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("abort_wbuf_on", 32'(bus.wbuf_on), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        sb.delete();
        repeat (3) @(negedge clk);
        skip_len = 1'b0;
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        run_case(1'b0, 5, 17, 1);

        // Asynchronous reset in the middle of a burst.
        push_bursts(1'b1, 8, 8, 1, n_exp);
        do_start(1'b1, 8, 8, 1);
        wait_on(50);
        @(negedge clk);
        skip_len = 1'b1;
        #2 reset = 1'b0;
        #1 check_reset_values("midrst");
        @(negedge clk);
        reset = 1'b1;
        sb.delete();
        repeat (2) @(negedge clk);
        skip_len = 1'b0;
        check("post_rst_busy", 32'(bus.busy), 32'd0);
        run_case(1'b1, 4, 20, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
